pixel_line_capture: RTL
=======================

# pixel_line_capture

Receive-side counterpart of the image stimulus source. Accepts the HSYNC-qualified 16-bit pixel stream, checks line length, and stores complete lines in a two-bank ping-pong line buffer. The downstream wavelet/SPIHT front end reads stored lines by address and releases each bank when it is done. Sits between the camera/stimulus port and the transform input stage.

## Interface
- IMG_WIDTH, 2048: pixels per line; must be a power of two, at least 4.
- IMG_HEIGHT, 2048: lines per frame.
- PIX_W, 16: pixel width.
- PCLK  in  1  sole clock, rising edge.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- HSYNC  in  1  high for exactly the cycles that carry valid pixels of one line.
- VSYNC  in  1  frame restart. Rising edge clears the row counter and aborts any line in progress.
- Pixel_DATA  in  PIX_W  pixel, valid when HSYNC=1.
- rd_addr  in  log2(IMG_WIDTH)  pixel index within the oldest full bank.
- rd_data  out  PIX_W  pixel at rd_addr; 1-cycle registered latency.
- line_valid  out  1  at least one full bank is waiting.
- line_bank  out  1  index of the oldest full bank (the bank rd_addr reads).
- line_row  out  log2(IMG_HEIGHT)  row number of the oldest full bank.
- line_release  in  1  one-cycle pulse; frees the oldest full bank.
- frame_done  out  1  one-cycle pulse when row IMG_HEIGHT-1 is committed.
- err_short, err_long, err_overflow  out  1 each  sticky error flags.
- err_clr  in  1  clears all three error flags.

## Operation
- State machine: IDLE, CAPT, DROP.
- IDLE to CAPT: on HSYNC rising (HSYNC=1, previous cycle 0) when the write bank is free. The first pixel is written at address 0 in that same cycle.
- IDLE to DROP: on HSYNC rising when both banks are full. Set err_overflow; discard pixels until HSYNC falls.
- CAPT: each cycle with HSYNC=1 and pix_cnt < IMG_WIDTH, write Pixel_DATA at pix_cnt, then pix_cnt++.
- CAPT, HSYNC=1 with pix_cnt == IMG_WIDTH: set err_long; discard the pixel.
- CAPT, HSYNC falling:
  - pix_cnt == IMG_WIDTH (with or without err_long): commit. Mark the bank full, tag it with the row, toggle the write bank, row++.
  - pix_cnt < IMG_WIDTH: set err_short. The bank stays free, row does not advance.
  - In both cases, return to IDLE.
- DROP, HSYNC falling: go to IDLE. Row does not advance; the line is lost.
- Row wrap: a commit with row == IMG_HEIGHT-1 pulses frame_done and sets row to 0.
- VSYNC rising has priority over everything: row = 0, state = IDLE, any partial line is discarded without an error. Already-full banks are kept.
- Commit and line_release in the same cycle: both take effect. The released bank is the oldest; the committed one becomes full.
- line_release with line_valid=0 is ignored.
- err_clr and a new error event in the same cycle: the error wins (flag stays set).
- Bank order is FIFO: line_bank always points at the older full bank. Once released, it points at the other bank if that bank is full.
- Reset values: state IDLE, both banks free, write bank 0, row 0, pix_cnt 0, rd_data 0, line_valid 0, line_bank 0, line_row 0, frame_done 0, all error flags 0. Buffer contents are undefined.

## Timing
- HSYNC falling is detected in cycle t (HSYNC=0, registered previous value = 1). line_valid and line_row update at t+1; frame_done pulses at t+1.
- line_release sampled at t: line_valid/line_bank update at t+1. The freed bank can be written by a line starting at t+1.
- rd_data at t+1 reflects rd_addr at t for the current line_bank.
- Minimum supported inter-line gap: 1 cycle of HSYNC=0.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package holds IMG_WIDTH, IMG_HEIGHT, PIX_W, ADDR_W = clog2(IMG_WIDTH), ROW_W, and the IDLE/CAPT/DROP state encodings. The stimulus source uses the same package.
- One sub-module, line_bank_ram: 2*IMG_WIDTH x PIX_W simple dual-port RAM with one write port, one registered read port, and address = {bank, index}.
- Everything else (FSM, counters, bank full/order bits, error flags) lives in the top level.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=4.
- 4 lines of pixels 0x0000..0x001F with 5-cycle gaps, release each line right after reading it. Reads return the exact values; line_row runs 0,1,2,3; frame_done pulses once after row 3; no errors.
- Line of 5 pixels, then a normal line. err_short=1; the normal line commits as row 0 in bank 0.
- Line of 10 pixels. err_long=1; pixels 0..7 are stored and committed; pixels 8..9 never appear.
- 3 lines with no release. The third sets err_overflow; line_valid stays 1; rows 0,1 are intact. Release once and send a 4th line: it commits as row 2.
- Release in the same cycle a commit is detected. The next cycle shows line_valid=1 and line_bank pointing at the new line.
- VSYNC pulse mid-line at pixel 3, then a full line. No error; the line commits as row 0. Reset asserted mid-line returns all outputs to their reset values on the next cycle.

Source files
------------

// File: rtl/pixel_line_capture_pkg.sv
// ---------------------------------------------------------------------------
// pixel_line_capture_pkg : shared image geometry and capture FSM encodings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pixel_line_capture_pkg;

  localparam int IMG_WIDTH  = 2048;
  localparam int IMG_HEIGHT = 2048;
  localparam int PIX_W      = 16;
  localparam int ADDR_W     = $clog2(IMG_WIDTH);
  localparam int ROW_W      = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_DROP = 2'd2
  } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_line_capture_if.sv
// ---------------------------------------------------------------------------
// pixel_line_capture_if : pixel stream, line read-out and status bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pixel_line_capture_if #(
  parameter int IMG_WIDTH  = pixel_line_capture_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = pixel_line_capture_pkg::IMG_HEIGHT,
  parameter int PIX_W      = pixel_line_capture_pkg::PIX_W
);
  import pixel_line_capture_pkg::*;

  localparam int IF_ADDR_W = $clog2(IMG_WIDTH);
  localparam int IF_ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic                 HSYNC;
  logic                 VSYNC;
  logic [PIX_W-1:0]     Pixel_DATA;
  logic [IF_ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]     rd_data;
  logic                 line_valid;
  logic                 line_bank;
  logic [IF_ROW_W-1:0]  line_row;
  logic                 line_release;
  logic                 frame_done;
  logic                 err_short;
  logic                 err_long;
  logic                 err_overflow;
  logic                 err_clr;

  modport master (
    output HSYNC, VSYNC, Pixel_DATA, rd_addr, line_release, err_clr,
    input  rd_data, line_valid, line_bank, line_row, frame_done,
           err_short, err_long, err_overflow
  );

  modport slave (
    input  HSYNC, VSYNC, Pixel_DATA, rd_addr, line_release, err_clr,
    output rd_data, line_valid, line_bank, line_row, frame_done,
           err_short, err_long, err_overflow
  );

endinterface

`default_nettype wire

// File: rtl/line_bank_ram.sv
// ---------------------------------------------------------------------------
// line_bank_ram : two-bank simple dual-port line store, registered read port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module line_bank_ram
  import pixel_line_capture_pkg::*;
#(
  parameter int DEPTH_W = ADDR_W + 1,
  parameter int DATA_W  = PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [DEPTH_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [DEPTH_W-1:0] i_raddr,
  output logic [DATA_W-1:0]  o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1 << DEPTH_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the read register is reset; the array itself holds no defined state.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata <= '0;
    end else begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_line_capture.sv
// ---------------------------------------------------------------------------
// pixel_line_capture : HSYNC line capture with length check into ping-pong banks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_line_capture #(
  parameter int IMG_WIDTH  = pixel_line_capture_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = pixel_line_capture_pkg::IMG_HEIGHT,
  parameter int PIX_W      = pixel_line_capture_pkg::PIX_W
) (
  input  logic                PCLK,
  input  logic                RST,
  pixel_line_capture_if.slave bus
);
  import pixel_line_capture_pkg::*;

  localparam int CAP_ADDR_W = $clog2(IMG_WIDTH);
  localparam int CAP_ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CAP_ADDR_W:0]  C_LINE_LEN = (CAP_ADDR_W + 1)'(IMG_WIDTH);
  localparam logic [CAP_ROW_W-1:0] C_LAST_ROW = CAP_ROW_W'(IMG_HEIGHT - 1);

  cap_state_t           r_state;
  cap_state_t           w_state_nxt;
  logic                 r_hs_d;
  logic                 r_vs_d;
  logic [CAP_ADDR_W:0]  r_pix_cnt;
  logic [1:0]           r_full;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic [CAP_ROW_W-1:0] r_row;
  logic [CAP_ROW_W-1:0] r_row_tag [2];
  logic                 r_frame_done;
  logic                 r_err_short;
  logic                 r_err_long;
  logic                 r_err_ovf;

  logic                 w_hs_rise;
  logic                 w_vs_rise;
  logic                 w_line_full;
  logic                 w_release;
  logic                 w_we;
  logic                 w_commit;
  logic                 w_short;
  logic                 w_long;
  logic                 w_ovf;
  logic [1:0]           w_commit_mask;
  logic [1:0]           w_release_mask;

  assign w_hs_rise   = bus.HSYNC & ~r_hs_d;
  assign w_vs_rise   = bus.VSYNC & ~r_vs_d;
  assign w_line_full = (r_pix_cnt == C_LINE_LEN);
  assign w_release   = bus.line_release & (|r_full);

  // The write bank is always the one after the newest full bank, so it being
  // full means both banks are full.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_commit    = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_ovf       = 1'b0;
    if (w_vs_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_hs_rise) begin
            if (!r_full[r_wr_bank]) begin
              w_state_nxt = ST_CAPT;
              w_we        = 1'b1;
            end else begin
              w_state_nxt = ST_DROP;
              w_ovf       = 1'b1;
            end
          end
        end
        ST_CAPT: begin
          if (bus.HSYNC) begin
            if (w_line_full) begin
              w_long = 1'b1;
            end else begin
              w_we = 1'b1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            if (w_line_full) begin
              w_commit = 1'b1;
            end else begin
              w_short = 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (!bus.HSYNC) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_commit_mask  = {w_commit & r_wr_bank, w_commit & ~r_wr_bank};
  assign w_release_mask = {w_release & r_rd_bank, w_release & ~r_rd_bank};

  always_ff @(posedge PCLK) begin
    if (RST) begin
      r_hs_d       <= 1'b0;
      r_vs_d       <= 1'b0;
      r_pix_cnt    <= '0;
      r_full       <= 2'b00;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_row        <= '0;
      r_row_tag[0] <= '0;
      r_row_tag[1] <= '0;
      r_frame_done <= 1'b0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_hs_d       <= bus.HSYNC;
      r_vs_d       <= bus.VSYNC;
      r_frame_done <= 1'b0;

      if (w_we) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end else if (w_state_nxt == ST_IDLE) begin
        r_pix_cnt <= '0;
      end

      if (w_vs_rise) begin
        r_row <= '0;
      end else if (w_commit) begin
        r_row_tag[r_wr_bank] <= r_row;
        r_wr_bank            <= ~r_wr_bank;
        if (r_row == C_LAST_ROW) begin
          r_row        <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end

      // Commit and release always target different banks, so both apply.
      r_full <= (r_full & ~w_release_mask) | w_commit_mask;
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end

      r_err_short <= (r_err_short & ~bus.err_clr) | w_short;
      r_err_long  <= (r_err_long  & ~bus.err_clr) | w_long;
      r_err_ovf   <= (r_err_ovf   & ~bus.err_clr) | w_ovf;
    end
  end

  line_bank_ram #(
    .DEPTH_W (CAP_ADDR_W + 1),
    .DATA_W  (PIX_W)
  ) u_ram (
    .clk     (PCLK),
    .rst     (RST),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, r_pix_cnt[CAP_ADDR_W-1:0]}),
    .i_wdata (bus.Pixel_DATA),
    .i_raddr ({r_rd_bank, bus.rd_addr}),
    .o_rdata (bus.rd_data)
  );

  assign bus.line_valid   = |r_full;
  assign bus.line_bank    = r_rd_bank;
  assign bus.line_row     = r_row_tag[r_rd_bank];
  assign bus.frame_done   = r_frame_done;
  assign bus.err_short    = r_err_short;
  assign bus.err_long     = r_err_long;
  assign bus.err_overflow = r_err_ovf;

endmodule

`default_nettype wire
